// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB register block: bus widths, register
// addresses, TCR/TSR bit positions, the transfer FSM state enum and the
// TCR field struct with pack/unpack helpers.
package timer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_TDR  = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_TCR  = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_TSR  = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_TCNT = 8'h03;

  localparam int unsigned TCR_LOAD_BIT = 7;
  localparam int unsigned TCR_DIR_BIT  = 5;
  localparam int unsigned TCR_EN_BIT   = 4;
  localparam int unsigned TCR_CKS_LSB  = 0;
  localparam int unsigned CKS_W        = 2;

  localparam int unsigned TSR_OVF_BIT = 0;
  localparam int unsigned TSR_UDF_BIT = 1;
  localparam int unsigned TSR_W       = 2;

  typedef enum logic [1:0] {
    XFER_IDLE = 2'd0,
    XFER_WAIT = 2'd1,
    XFER_DONE = 2'd2
  } xfer_state_t;

  // Storable TCR fields; the load bit is a strobe and is never stored.
  typedef struct packed {
    logic             dir;
    logic             en;
    logic [CKS_W-1:0] cks;
  } tcr_t;

  function automatic logic [DATA_W-1:0] tcr_readback(input tcr_t t);
    logic [DATA_W-1:0] r;
    r = '0;
    r[TCR_DIR_BIT] = t.dir;
    r[TCR_EN_BIT]  = t.en;
    r[TCR_CKS_LSB +: CKS_W] = t.cks;
    return r;
  endfunction

  function automatic tcr_t tcr_from_wdata(input logic [DATA_W-1:0] d);
    tcr_t t;
    t.dir = d[TCR_DIR_BIT];
    t.en  = d[TCR_EN_BIT];
    t.cks = d[TCR_CKS_LSB +: CKS_W];
    return t;
  endfunction

endpackage

// File: rtl/timer_w1c_bit.sv
// Single status flop with write-1-to-clear and set priority.
// Ports: clk, rst_n (async active-low), set (event pulse), clr (W1C strobe),
// q (status bit).
module timer_w1c_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  // An event arriving in the same cycle as a clear must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_apb_regs.sv
// APB register block for the timer core: TDR reload value, TCR control,
// TSR status (RW1C) and read-only TCNT. Every transfer takes one WAIT cycle
// before pready is raised in DONE.
// Ports: cpu_clk/cpu_rstn clock and async active-low reset; psel, penable,
// pwrite, paddr, pwdata APB request; prdata, pready, pslverr APB response;
// tcnt live counter; ovf_set/udf_set event pulses; tdr, tcr_en, tcr_dir,
// tcr_cks, load_pulse register outputs to the timer core.
module timer_apb_regs
  import timer_pkg::*;
(
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [DATA_W-1:0] tcnt,
  input  logic              ovf_set,
  input  logic              udf_set,
  output logic [DATA_W-1:0] tdr,
  output logic              tcr_en,
  output logic              tcr_dir,
  output logic [CKS_W-1:0]  tcr_cks,
  output logic              load_pulse
);

  xfer_state_t       state;
  tcr_t              tcr_q;
  logic [TSR_W-1:0]  tsr_q;

  logic              access_c;
  logic              err_c;
  logic              wr_commit_c;
  logic              tsr_wr_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [TSR_W-1:0]  tsr_set_c;
  logic [TSR_W-1:0]  tsr_clr_c;

  assign access_c = psel & penable;

  // Out-of-map addresses and any write to the read-only counter are errors.
  assign err_c = (paddr > ADDR_TCNT) | (pwrite & (paddr == ADDR_TCNT));

  // Master holds the request through DONE, so live bus values are committed.
  assign wr_commit_c = (state == XFER_DONE) & access_c & pwrite & ~pslverr;
  assign tsr_wr_c    = wr_commit_c & (paddr == ADDR_TSR);

  // Read data mux.
  always_comb begin
    rd_data_c = '0;
    case (paddr)
      ADDR_TDR:  rd_data_c = tdr;
      ADDR_TCR:  rd_data_c = tcr_readback(tcr_q);
      ADDR_TSR:  rd_data_c = DATA_W'(tsr_q);
      ADDR_TCNT: rd_data_c = tcnt;
      default:   rd_data_c = '0;
    endcase
  end

  // Transfer FSM with registered response; response is valid only in DONE.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state   <= XFER_IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      case (state)
        XFER_IDLE: begin
          if (access_c) state <= XFER_WAIT;
        end
        XFER_WAIT: begin
          if (access_c) begin
            state   <= XFER_DONE;
            pready  <= 1'b1;
            pslverr <= err_c;
            if (!pwrite && !err_c) prdata <= rd_data_c;
          end else begin
            state <= XFER_IDLE;
          end
        end
        XFER_DONE: state <= XFER_IDLE;
        default:   state <= XFER_IDLE;
      endcase
    end
  end

  // TDR/TCR storage and the one-cycle load strobe.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      tdr        <= '0;
      tcr_q      <= '0;
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      if (wr_commit_c && paddr == ADDR_TDR) begin
        tdr <= pwdata;
      end
      if (wr_commit_c && paddr == ADDR_TCR) begin
        tcr_q      <= tcr_from_wdata(pwdata);
        load_pulse <= pwdata[TCR_LOAD_BIT];
      end
    end
  end

  assign tcr_en  = tcr_q.en;
  assign tcr_dir = tcr_q.dir;
  assign tcr_cks = tcr_q.cks;

  // TSR status bits.
  always_comb begin
    tsr_set_c = '0;
    tsr_set_c[TSR_OVF_BIT] = ovf_set;
    tsr_set_c[TSR_UDF_BIT] = udf_set;
  end

  assign tsr_clr_c = {TSR_W{tsr_wr_c}} & pwdata[TSR_W-1:0];

  for (genvar i = 0; i < TSR_W; i++) begin : g_tsr
    timer_w1c_bit u_bit (
      .clk   (cpu_clk),
      .rst_n (cpu_rstn),
      .set   (tsr_set_c[i]),
      .clr   (tsr_clr_c[i]),
      .q     (tsr_q[i])
    );
  end

endmodule

// File: tb/tb_timer_apb_regs.sv
// Self-checking bench for timer_apb_regs: directed scenarios plus randomized
// APB traffic against a register-map level model.
module tb_timer_apb_regs;

  logic       cpu_clk = 1'b0;
  logic       cpu_rstn;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata, tcnt, tdr;
  logic       pready, pslverr, ovf_set, udf_set;
  logic       tcr_en, tcr_dir, load_pulse;
  logic [1:0] tcr_cks;

  int checks = 0;
  int failures = 0;

  // Model state: readback images of TDR, TCR and TSR.
  logic [7:0] m_tdr, m_tcr, m_tsr;

  // Access-phase cycle in which pready appears: IDLE cycle, one WAIT cycle, DONE.
  localparam int EXP_LAT = 3;

  always #5 cpu_clk = ~cpu_clk;

  timer_apb_regs dut (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .tcnt       (tcnt),
    .ovf_set    (ovf_set),
    .udf_set    (udf_set),
    .tdr        (tdr),
    .tcr_en     (tcr_en),
    .tcr_dir    (tcr_dir),
    .tcr_cks    (tcr_cks),
    .load_pulse (load_pulse)
  );

  function automatic logic m_err(input logic wr, input logic [7:0] a);
    return (a > 8'h03) || (wr && a == 8'h03);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return m_tsr;
      8'h03:   return tcnt;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void m_reset();
    m_tdr = 8'h00;
    m_tcr = 8'h00;
    m_tsr = 8'h00;
  endfunction

  // Effect of a completed transfer plus events pulsed in its final cycle.
  function automatic void m_commit(input logic wr, input logic [7:0] a,
                                   input logic [7:0] wd, input logic [1:0] evt);
    if (wr && !m_err(wr, a)) begin
      case (a)
        8'h00:   m_tdr = wd;
        8'h01:   m_tcr = wd & 8'h33;
        8'h02:   m_tsr = m_tsr & ~wd;
        default: ;
      endcase
    end
    m_tsr = m_tsr | {6'b0, evt};
  endfunction

  // One APB transfer; evt is driven on ovf/udf during the DONE cycle.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [1:0] evt, output logic [7:0] rd,
                          output logic err, output int lat, output logic lp);
    @(posedge cpu_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge cpu_clk); #1;
    penable = 1'b1;
    lat = 1;
    while (pready !== 1'b1 && lat < 8) begin
      checks++;
      if (prdata !== 8'h00) begin
        failures++;
        $display("FAIL prdata_idle got=%h exp=00 addr=%h", prdata, a);
      end
      @(posedge cpu_clk); #1;
      lat++;
    end
    checks++;
    if (pready !== 1'b1) begin
      failures++;
      $display("FAIL pready_timeout got=%b exp=1 addr=%h", pready, a);
    end
    rd = prdata;
    err = pslverr;
    ovf_set = evt[0];
    udf_set = evt[1];
    @(posedge cpu_clk); #1;
    ovf_set = 1'b0; udf_set = 1'b0;
    psel = 1'b0; penable = 1'b0;
    lp = load_pulse;
  endtask

  task automatic pulse_evt(input logic [1:0] evt);
    @(posedge cpu_clk); #1;
    ovf_set = evt[0]; udf_set = evt[1];
    @(posedge cpu_clk); #1;
    ovf_set = 1'b0; udf_set = 1'b0;
    m_tsr = m_tsr | {6'b0, evt};
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic err, lp; int lat;
    cpu_rstn = 1'b0;
    #1;
    checks++;
    if ({prdata, pready, pslverr, load_pulse, tdr, tcr_en, tcr_dir, tcr_cks} !== 22'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000000",
               {prdata, pready, pslverr, load_pulse, tdr, tcr_en, tcr_dir, tcr_cks});
    end
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    m_reset();
    for (int a = 0; a < 3; a++) begin
      apb_xfer(1'b0, 8'(a), 8'h00, 2'b00, rd, err, lat, lp);
      checks++;
      if (rd !== 8'h00 || err !== 1'b0) begin
        failures++;
        $display("FAIL reset_read addr=%0d got=%h/%b exp=00/0", a, rd, err);
      end
    end
  endtask

  task automatic test_tdr();
    logic [7:0] rd; logic err, lp; int lat;
    apb_xfer(1'b1, 8'h00, 8'hA5, 2'b00, rd, err, lat, lp);
    m_commit(1'b1, 8'h00, 8'hA5, 2'b00);
    checks++;
    if (err !== 1'b0 || lat != EXP_LAT) begin
      failures++;
      $display("FAIL tdr_write got=err%b lat%0d exp=err0 lat%0d", err, lat, EXP_LAT);
    end
    checks++;
    if (tdr !== 8'hA5) begin
      failures++;
      $display("FAIL tdr_output got=%h exp=a5", tdr);
    end
    apb_xfer(1'b0, 8'h00, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== 8'hA5 || err !== 1'b0 || lat != EXP_LAT) begin
      failures++;
      $display("FAIL tdr_read got=%h err%b lat%0d exp=a5 err0 lat%0d", rd, err, lat, EXP_LAT);
    end
  endtask

  task automatic test_tcr();
    logic [7:0] rd; logic err, lp; int lat;
    apb_xfer(1'b1, 8'h01, 8'hB3, 2'b00, rd, err, lat, lp);
    m_commit(1'b1, 8'h01, 8'hB3, 2'b00);
    checks++;
    if (lp !== 1'b1) begin
      failures++;
      $display("FAIL tcr_load_pulse got=%b exp=1", lp);
    end
    checks++;
    if ({tcr_en, tcr_dir, tcr_cks} !== 4'b1111) begin
      failures++;
      $display("FAIL tcr_fields got=%b exp=1111", {tcr_en, tcr_dir, tcr_cks});
    end
    @(posedge cpu_clk); #1;
    checks++;
    if (load_pulse !== 1'b0) begin
      failures++;
      $display("FAIL tcr_load_one_cycle got=%b exp=0", load_pulse);
    end
    apb_xfer(1'b0, 8'h01, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== 8'h33 || err !== 1'b0) begin
      failures++;
      $display("FAIL tcr_read got=%h err%b exp=33 err0", rd, err);
    end
    // Load bit clear: fields change, no strobe.
    apb_xfer(1'b1, 8'h01, 8'h4E, 2'b00, rd, err, lat, lp);
    m_commit(1'b1, 8'h01, 8'h4E, 2'b00);
    checks++;
    if (lp !== 1'b0 || {tcr_en, tcr_dir, tcr_cks} !== 4'b0010) begin
      failures++;
      $display("FAIL tcr_noload got=%b/%b exp=0/0010", lp, {tcr_en, tcr_dir, tcr_cks});
    end
  endtask

  task automatic test_tsr();
    logic [7:0] rd; logic err, lp; int lat;
    pulse_evt(2'b01);
    apb_xfer(1'b0, 8'h02, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== 8'h01) begin
      failures++;
      $display("FAIL tsr_ovf_set got=%h exp=01", rd);
    end
    apb_xfer(1'b1, 8'h02, 8'h01, 2'b00, rd, err, lat, lp);
    m_commit(1'b1, 8'h02, 8'h01, 2'b00);
    apb_xfer(1'b0, 8'h02, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== 8'h00) begin
      failures++;
      $display("FAIL tsr_w1c got=%h exp=00", rd);
    end
    pulse_evt(2'b01);
    apb_xfer(1'b1, 8'h02, 8'h01, 2'b01, rd, err, lat, lp);
    m_commit(1'b1, 8'h02, 8'h01, 2'b01);
    apb_xfer(1'b0, 8'h02, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== 8'h01) begin
      failures++;
      $display("FAIL tsr_set_wins got=%h exp=01", rd);
    end
    pulse_evt(2'b10);
    apb_xfer(1'b1, 8'h02, 8'hFE, 2'b00, rd, err, lat, lp);
    m_commit(1'b1, 8'h02, 8'hFE, 2'b00);
    apb_xfer(1'b0, 8'h02, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== 8'h01) begin
      failures++;
      $display("FAIL tsr_udf_clear_only got=%h exp=01", rd);
    end
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic err, lp; int lat;
    tcnt = 8'h11;
    apb_xfer(1'b1, 8'h03, 8'h55, 2'b00, rd, err, lat, lp);
    checks++;
    if (err !== 1'b1 || lat != EXP_LAT) begin
      failures++;
      $display("FAIL err_write_tcnt got=err%b lat%0d exp=err1 lat%0d", err, lat, EXP_LAT);
    end
    apb_xfer(1'b0, 8'h10, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin
      failures++;
      $display("FAIL err_read_oob got=%h err%b exp=00 err1", rd, err);
    end
    apb_xfer(1'b1, 8'h80, 8'h77, 2'b00, rd, err, lat, lp);
    checks++;
    if (err !== 1'b1 || tdr !== m_tdr || {tcr_dir, tcr_en, tcr_cks} !== {m_tcr[5:4], m_tcr[1:0]}) begin
      failures++;
      $display("FAIL err_write_oob got=err%b tdr%h exp=err1 tdr%h", err, tdr, m_tdr);
    end
    for (int a = 0; a < 3; a++) begin
      apb_xfer(1'b0, 8'(a), 8'h00, 2'b00, rd, err, lat, lp);
      checks++;
      if (rd !== m_read(8'(a)) || err !== 1'b0) begin
        failures++;
        $display("FAIL err_regs_unchanged addr=%0d got=%h exp=%h", a, rd, m_read(8'(a)));
      end
    end
  endtask

  task automatic test_tcnt_and_abort();
    logic [7:0] rd; logic err, lp; int lat; int seen;
    tcnt = 8'h7E;
    apb_xfer(1'b0, 8'h03, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== 8'h7E || err !== 1'b0) begin
      failures++;
      $display("FAIL tcnt_read got=%h err%b exp=7e err0", rd, err);
    end
    // psel dropped during the WAIT cycle.
    @(posedge cpu_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h3C;
    @(posedge cpu_clk); #1;
    penable = 1'b1;
    @(posedge cpu_clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 0;
    repeat (4) begin
      if (pready === 1'b1) seen++;
      @(posedge cpu_clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_pready got=%0d exp=0", seen);
    end
    // penable without psel.
    pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h99; penable = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge cpu_clk); #1;
      if (pready === 1'b1) seen++;
    end
    penable = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL penable_only_pready got=%0d exp=0", seen);
    end
    apb_xfer(1'b0, 8'h00, 8'h00, 2'b00, rd, err, lat, lp);
    checks++;
    if (rd !== m_tdr) begin
      failures++;
      $display("FAIL abort_no_write got=%h exp=%h", rd, m_tdr);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, wd, rd, exp_rd; logic wr, err, lp, exp_err, exp_lp; int lat;
    logic [1:0] evt;
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      wd = 8'($urandom);
      tcnt = 8'($urandom);
      evt = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      exp_err = m_err(wr, a);
      exp_rd = (wr || exp_err) ? 8'h00 : m_read(a);
      exp_lp = wr && !exp_err && a == 8'h01 && wd[7];
      apb_xfer(wr, a, wd, evt, rd, err, lat, lp);
      m_commit(wr, a, wd, evt);
      checks++;
      if (rd !== exp_rd || err !== exp_err || lat != EXP_LAT || lp !== exp_lp) begin
        failures++;
        $display("FAIL rand_xfer i=%0d wr=%b a=%h got=%h/%b/%0d/%b exp=%h/%b/%0d/%b",
                 i, wr, a, rd, err, lat, lp, exp_rd, exp_err, EXP_LAT, exp_lp);
      end
      checks++;
      if (tdr !== m_tdr || {tcr_dir, tcr_en, tcr_cks} !== {m_tcr[5:4], m_tcr[1:0]}) begin
        failures++;
        $display("FAIL rand_outputs i=%0d got=%h/%b exp=%h/%b", i, tdr,
                 {tcr_dir, tcr_en, tcr_cks}, m_tdr, {m_tcr[5:4], m_tcr[1:0]});
      end
      if ($urandom_range(0, 3) == 0) pulse_evt(2'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic err, lp; int lat;
    apb_xfer(1'b1, 8'h01, 8'h37, 2'b00, rd, err, lat, lp);
    m_commit(1'b1, 8'h01, 8'h37, 2'b00);
    apb_xfer(1'b1, 8'h00, 8'h5A, 2'b00, rd, err, lat, lp);
    m_commit(1'b1, 8'h00, 8'h5A, 2'b00);
    pulse_evt(2'b11);
    @(posedge cpu_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
    @(posedge cpu_clk); #1;
    penable = 1'b1;
    @(posedge cpu_clk); #1;
    cpu_rstn = 1'b0;
    #1;
    checks++;
    if ({prdata, pready, pslverr, load_pulse, tdr, tcr_en, tcr_dir, tcr_cks} !== 22'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=000000",
               {prdata, pready, pslverr, load_pulse, tdr, tcr_en, tcr_dir, tcr_cks});
    end
    @(posedge cpu_clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    m_reset();
    for (int a = 0; a < 3; a++) begin
      apb_xfer(1'b0, 8'(a), 8'h00, 2'b00, rd, err, lat, lp);
      checks++;
      if (rd !== 8'h00 || err !== 1'b0 || lat != EXP_LAT) begin
        failures++;
        $display("FAIL midreset_read addr=%0d got=%h err%b lat%0d exp=00 err0 lat%0d",
                 a, rd, err, lat, EXP_LAT);
      end
    end
  endtask

  initial begin
    cpu_rstn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; tcnt = 8'h00;
    ovf_set = 1'b0; udf_set = 1'b0;
    m_reset();
    test_reset();
    test_tdr();
    test_tcr();
    test_tsr();
    test_errors();
    test_tcnt_and_abort();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
